// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Imported by divider_nbit; holds the FSM encoding and width helpers.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEFAULT_DIV_BITS = 4;

    // Iteration counter width; one spare bit so the counter never wraps within an operation.
    function automatic int div_cnt_width(input int num_bits);
        return $clog2(num_bits) + 1;
    endfunction

endpackage

// File: rtl/sub_nbit.sv
// Combinational ripple subtractor: diff = a - b computed as a + ~b + 1.
// borrow_out is high when b > a (i.e. the final carry is clear).
module sub_nbit #(
    parameter int NUM_BITS = 4
) (
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    output logic [NUM_BITS-1:0] diff,
    output logic                borrow_out
);

    logic [NUM_BITS-1:0] b_inv_s;
    logic [NUM_BITS:0]   carry_s;

    assign b_inv_s    = ~b;
    assign borrow_out = ~carry_s[NUM_BITS];

    // Full-adder ripple chain with the carry seeded to one for two's-complement subtraction.
    always_comb begin
        diff       = '0;
        carry_s    = '0;
        carry_s[0] = 1'b1;
        for (int i = 0; i < NUM_BITS; i++) begin
            diff[i]      = a[i] ^ b_inv_s[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b_inv_s[i]) | (carry_s[i] & (a[i] ^ b_inv_s[i]));
        end
    end

endmodule

// File: rtl/divider_nbit.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// registered results with a one-cycle done pulse and a divide-by-zero flag.
module divider_nbit
    import divider_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_DIV_BITS
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] dividend,
    input  logic [NUM_BITS-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] quotient,
    output logic [NUM_BITS-1:0] remainder,
    output logic                div_by_zero
);

    localparam int CNT_W = div_cnt_width(NUM_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

    div_state_t            state_r;
    logic [CNT_W-1:0]      count_r;
    logic [NUM_BITS-1:0]   rem_r;
    logic [NUM_BITS-1:0]   quo_r;
    logic [NUM_BITS-1:0]   divisor_r;

    logic [NUM_BITS:0]     rem_shift_s;
    logic [NUM_BITS:0]     trial_s;
    logic                  borrow_s;
    logic [NUM_BITS-1:0]   rem_next_s;
    logic [NUM_BITS-1:0]   quo_next_s;
    logic                  unused_trial_msb_s;

    // Shifted partial remainder is one bit wider so the trial subtraction cannot overflow.
    assign rem_shift_s = {rem_r, quo_r[NUM_BITS-1]};

    sub_nbit #(
        .NUM_BITS (NUM_BITS + 1)
    ) u_sub (
        .a          (rem_shift_s),
        .b          ({1'b0, divisor_r}),
        .diff       (trial_s),
        .borrow_out (borrow_s)
    );

    // A successful trial always leaves the top bit clear, so only the low bits are kept.
    assign unused_trial_msb_s = trial_s[NUM_BITS];

    // Restore on borrow, otherwise accept the trial difference and shift in a one.
    always_comb begin
        quo_next_s = {quo_r[NUM_BITS-2:0], ~borrow_s};
        if (borrow_s) begin
            rem_next_s = rem_shift_s[NUM_BITS-1:0];
        end else begin
            rem_next_s = trial_s[NUM_BITS-1:0];
        end
    end

    // Control FSM, iteration counter, working registers and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= IDLE;
            count_r     <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            divisor_r   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        divisor_r <= divisor;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            rem_r   <= '0;
                            quo_r   <= dividend;
                            count_r <= '0;
                            busy    <= 1'b1;
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_r   <= rem_next_s;
                    quo_r   <= quo_next_s;
                    count_r <= count_r + CNT_W'(1);
                    if (count_r == LAST_CNT) begin
                        quotient    <= quo_next_s;
                        remainder   <= rem_next_s;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_nbit.sv
// Self-checking bench for divider_nbit at NUM_BITS=4: directed vectors, reset
// robustness, and an exhaustive sweep checked against a plain-arithmetic model.
module tb_divider_nbit;

    localparam int NB = 4;

    logic          clk;
    logic          n_rst;
    logic          start;
    logic [NB-1:0] dividend;
    logic [NB-1:0] divisor;
    logic          busy;
    logic          done;
    logic [NB-1:0] quotient;
    logic [NB-1:0] remainder;
    logic          div_by_zero;

    int checks = 0;
    int fails  = 0;

    // Results the outputs must currently show, and the operation in flight.
    logic [NB-1:0] cur_q, cur_r;
    logic          cur_dz;
    logic [NB-1:0] pend_a, pend_b;
    bit            pend_valid = 1'b0;
    bit            prev_done  = 1'b0;

    divider_nbit #(.NUM_BITS(NB)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                         output logic [NB-1:0] q, output logic [NB-1:0] r, output logic dz);
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endtask

    // Per-cycle compare: outputs must always equal the latest completed result.
    always @(negedge clk) begin
        if (!n_rst) begin
            pend_valid = 1'b0;
            cur_q      = '0;
            cur_r      = '0;
            cur_dz     = 1'b0;
        end else if (done) begin
            if (!pend_valid) begin
                chk("unexpected_done", 1, 0);
            end else begin
                model(pend_a, pend_b, cur_q, cur_r, cur_dz);
                pend_valid = 1'b0;
            end
        end
        if (n_rst && done && prev_done) chk("done_two_cycles", 1, 0);
        prev_done = done;
        chk("cyc_quotient", quotient, cur_q);
        chk("cyc_remainder", remainder, cur_r);
        chk("cyc_div_by_zero", div_by_zero, cur_dz);
    end

    task automatic do_div(input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input int eq, input int er, input int edz, input bit disturb);
        int k, nb;
        bit got;
        @(negedge clk);
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        pend_a     = a;
        pend_b     = b;
        pend_valid = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = NB'($urandom);
        divisor  = NB'($urandom);
        k = 0; nb = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (busy) nb++;
            if (done) got = 1'b1;
            start = disturb && (k == 2) && !got;
            if (start) begin
                dividend = ~a;
                divisor  = b + 4'd1;
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("latency", k, (b == 0) ? 1 : NB + 1);
        chk("busy_cycles", nb, (b == 0) ? 0 : NB);
        chk("busy_at_done", busy, 0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, edz);
        @(negedge clk);
        chk("done_pulse_end", done, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_quotient"}, quotient, 0);
        chk({tag, "_remainder"}, remainder, 0);
        chk({tag, "_dbz"}, div_by_zero, 0);
    endtask

    initial begin
        logic [NB-1:0] mq, mr;
        logic          mdz;
        int            ncases;

        n_rst    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        cur_q    = '0;
        cur_r    = '0;
        cur_dz   = 1'b0;

        // Pin the model against hand-computed values.
        model(4'd13, 4'd3, mq, mr, mdz);
        chk("model_13_3_q", mq, 4);
        chk("model_13_3_r", mr, 1);
        model(4'd9, 4'd0, mq, mr, mdz);
        chk("model_9_0_q", mq, 15);
        chk("model_9_0_dz", mdz, 1);

        #3;
        chk_all_zero("in_reset");
        #9 n_rst = 1'b1;

        repeat (10) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end

        do_div(4'd13, 4'd3, 4, 1, 0, 1'b0);
        do_div(4'd15, 4'd1, 15, 0, 0, 1'b0);
        do_div(4'd5, 4'd7, 0, 5, 0, 1'b0);
        do_div(4'd0, 4'd9, 0, 0, 0, 1'b0);
        do_div(4'd15, 4'd15, 1, 0, 0, 1'b0);
        do_div(4'd9, 4'd0, 15, 9, 1, 1'b0);
        do_div(4'd8, 4'd2, 4, 0, 0, 1'b0);

        // Asynchronous reset away from any edge clears nonzero results at once.
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        #2 n_rst = 1'b1;

        // Start re-pulsed with different operands mid-CALC must be ignored.
        do_div(4'd11, 4'd2, 5, 1, 0, 1'b1);

        // Reset in the second CALC cycle aborts without a done.
        @(negedge clk);
        dividend   = 4'd13;
        divisor    = 4'd3;
        start      = 1'b1;
        pend_a     = 4'd13;
        pend_b     = 4'd3;
        pend_valid = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1 chk_all_zero("abort_reset");
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_no_busy", busy, 0);
        end
        do_div(4'd13, 4'd3, 4, 1, 0, 1'b0);

        ncases = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                model(NB'(a), NB'(b), mq, mr, mdz);
                do_div(NB'(a), NB'(b), mq, mr, mdz, 1'b0);
                ncases++;
            end
        end
        $display("exhaustive cases run: %0d", ncases);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
